// File: rtl/result_bcd_display.sv
// result_bcd_display: converts the selected 16-bit result (g or h) to five
// BCD digits with a sequential shift-add-3 engine and drives five active-low
// seven-segment digits (hex0 = ones ... hex4 = ten-thousands).
// Optional feature macro: LEADING_ZERO_BLANK_EN -- blanks leading zero digits
// above the ones digit while a result is displayed.
module result_bcd_display (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic        sel,
    input  logic [15:0] g,
    input  logic [15:0] h,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic        busy,
    output logic        valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] disp_q, disp_d;
    logic [15:0] last_q, last_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic [15:0] src;
    logic [19:0] bcd_adj;
    logic        unused_bcd_msb;

    assign src = sel ? g : h;

    // Per-nibble add-3 on the pre-shift digits; done in parallel each cycle.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // 65535 fits in 20 BCD bits, so the bit shifted out of the top is always 0.
    assign unused_bcd_msb = bcd_adj[19];

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (done && (!valid_q || (src != last_q))) begin
                    shreg_d = src;
                    last_d  = src;
                    bcd_d   = 20'd0;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = {bcd_adj[18:0], shreg_q[15]};
                shreg_d = {shreg_q[14:0], 1'b0};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd15)
                    state_d = FINISH;
            end
            FINISH: begin
                disp_d  = bcd_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;  // illegal encoding: recover, touch nothing else
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= 16'd0;
            bcd_q   <= 20'd0;
            cnt_q   <= 5'd0;
            disp_q  <= 20'd0;
            last_q  <= 16'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [4:0]      blank;
    logic [4:0][6:0] hex_w;

    // Leading-zero mask: a digit blanks only if it and every higher digit are 0.
    always_comb begin
        blank = 5'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank[4] = (disp_q[19:16] == 4'd0);
        blank[3] = blank[4] && (disp_q[15:12] == 4'd0);
        blank[2] = blank[3] && (disp_q[11:8]  == 4'd0);
        blank[1] = blank[2] && (disp_q[7:4]   == 4'd0);
`endif
    end

    // Segment decode; everything dark until a first conversion completes.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            hex_w[k] = (!valid_q || blank[k]) ? 7'h7F : seg7(disp_q[4*k +: 4]);
        end
    end

    assign hex0  = hex_w[0];
    assign hex1  = hex_w[1];
    assign hex2  = hex_w[2];
    assign hex3  = hex_w[3];
    assign hex4  = hex_w[4];
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule
